// File: rtl/tt_um_islam_ihfaz_logic_tester.sv
// Self-sequencing tester for the 3-input cell x = (A & B) | ~C, y = ~C.
// Sweeps all 8 input vectors onto uio_out[2:0], samples {y,x} from
// uio_in[4:3] (or from an internal loopback model) after a settle delay,
// and reports busy/done/pass/fail, the mismatch count and the first failing vector.
module tt_um_islam_ihfaz_logic_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned COUNT_W  = 4;
  localparam int unsigned VEC_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Reference model of the cell under test; returns {y, x}.
  function automatic logic [1:0] cell_model(input logic [VEC_W-1:0] v);
    logic a, b, c;
    a = v[0];
    b = v[1];
    c = v[2];
    return {~c, (a & b) | ~c};
  endfunction

  state_e               state_q;
  logic [VEC_W-1:0]     vec_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic [COUNT_W-1:0]   count_q;
  logic [COUNT_W-1:0]   count_d;
  logic [VEC_W-1:0]     first_q;
  logic [VEC_W-1:0]     first_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 fail_q;
  logic [VEC_W-1:0]     drive_q;
  logic                 start_meta_q;
  logic                 start_sync_q;
  logic                 start_prev_q;

  logic                 start_evt_c;
  logic [1:0]           exp_c;
  logic [1:0]           obs_c;
  logic                 mismatch_c;

  // Start edge detect on the synchronized start input.
  assign start_evt_c = start_sync_q & ~start_prev_q;

  // Expected vs observed response and the updated result registers for SAMPLE.
  always_comb begin
    exp_c      = cell_model(vec_q);
    obs_c      = uio_in[4:3];
    if (ui_in[1]) begin
      obs_c = exp_c ^ {1'b0, ui_in[2]};
    end
    mismatch_c = (obs_c != exp_c);
    count_d    = count_q;
    first_d    = first_q;
    if (mismatch_c) begin
      count_d = count_q + COUNT_W'(1);
      if (count_q == '0) begin
        first_d = vec_q;
      end
    end
  end

  // Start synchronizer plus the sweep sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      count_q      <= '0;
      first_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      drive_q      <= '0;
    end else begin
      start_meta_q <= ui_in[0];
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_evt_c) begin
            state_q  <= ST_RUN;
            vec_q    <= '0;
            settle_q <= SETTLE_W'(SETTLE_CYCLES);
            count_q  <= '0;
            first_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            drive_q  <= '0;
          end
        end
        ST_RUN: begin
          settle_q <= settle_q - SETTLE_W'(1);
          if (settle_q <= SETTLE_W'(1)) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          count_q <= count_d;
          first_q <= first_d;
          if (vec_q == VEC_W'(7)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (count_d == '0);
            fail_q  <= (count_d != '0);
            drive_q <= '0;
          end else begin
            state_q  <= ST_RUN;
            vec_q    <= vec_q + VEC_W'(1);
            drive_q  <= vec_q + VEC_W'(1);
            settle_q <= SETTLE_W'(SETTLE_CYCLES);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output packing; every field comes straight from a flop.
  assign uo_out  = {count_q, fail_q, pass_q, done_q, busy_q};
  assign uio_out = {first_q, 2'b00, drive_q};
  assign uio_oe  = 8'hE7;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in[7:5], uio_in[2:0]};

endmodule

// File: tb/tb_tt_um_islam_ihfaz_logic_tester.sv
// Directed bench for the logic-cell tester: loopback pass/fault, an emulated
// external cell with x stuck at 1, start ignored mid-run, reset mid-run and
// restart from DONE. Final results go through a scoreboard queue.
module tb_tt_um_islam_ihfaz_logic_tester;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ext_stuck_x;

  int n_vec;
  int n_err;

  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];

  tt_um_islam_ihfaz_logic_tester #(.SETTLE_CYCLES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated external cell: y = ~C always, x = (A&B)|~C unless stuck at 1.
  assign uio_in = {3'b000,
                   ~uio_out[2],
                   ext_stuck_x ? 1'b1 : ((uio_out[0] & uio_out[1]) | ~uio_out[2]),
                   3'b000};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full sweep: mode = ui_in[2:1] settings, stuck = external x stuck at 1,
  // poke = pulse start again while vector 3 is running.
  task automatic do_sweep(input string name, input logic [7:0] mode, input bit stuck, input bit poke);
    int         cnt;
    logic [2:0] ff;
    int         cnt_before[8];
    logic [2:0] ff_before[8];
    logic [1:0] e;
    logic [1:0] o;
    logic [2:0] vv;
    exp_t       x;
    exp_t       got;

    ext_stuck_x = stuck;
    cnt = 0;
    ff  = 3'd0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      cnt_before[v] = cnt;
      ff_before[v]  = ff;
      e = {~vv[2], (vv[0] & vv[1]) | ~vv[2]};
      if (mode[1]) o = {e[1], e[0] ^ mode[2]};
      else         o = {~vv[2], stuck ? 1'b1 : e[0]};
      if (o != e) begin
        if (cnt == 0) ff = vv;
        cnt++;
      end
    end
    x.tag = name;
    x.uo  = {4'(cnt), (cnt != 0), (cnt == 0), 1'b1, 1'b0};
    x.uio = {ff, 5'b00000};
    sb.push_back(x);

    ui_in = mode & 8'hFE;
    tick(4);
    ui_in = mode | 8'h01;
    tick(3);
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 3; c++) begin
        if (poke && v == 1 && c == 0) ui_in[0] = 1'b0;
        if (poke && v == 3 && c == 0) ui_in[0] = 1'b1;
        check($sformatf("%s uo v%0d c%0d", name, v, c), uo_out,
              {4'(cnt_before[v]), 4'b0001});
        check($sformatf("%s uio v%0d c%0d", name, v, c), uio_out,
              {ff_before[v], 2'b00, 3'(v)});
        tick(1);
      end
    end
    ui_in = mode & 8'hFE;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", name);
    end else begin
      got = sb.pop_front();
      check({got.tag, " done uo"}, uo_out, got.uo);
      check({got.tag, " done uio"}, uio_out, got.uio);
    end
    tick(2);
    check({name, " hold uo"}, uo_out, x.uo);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    ena         = 1'b1;
    ui_in       = 8'h00;
    ext_stuck_x = 1'b0;
    rst_n       = 1'b0;

    // Reset and idle.
    tick(2);
    check("reset uo", uo_out, 8'h00);
    check("reset uio", uio_out, 8'h00);
    check("reset oe", uio_oe, 8'hE7);
    rst_n = 1'b1;
    tick(10);
    check("idle uo", uo_out, 8'h00);
    check("idle uio", uio_out, 8'h00);
    check("idle oe", uio_oe, 8'hE7);

    // Loopback pass, loopback fault, external stuck-x, restart from DONE.
    do_sweep("loop_pass", 8'h02, 1'b0, 1'b0);
    do_sweep("loop_fault", 8'h06, 1'b0, 1'b0);
    do_sweep("ext_stuck", 8'h00, 1'b1, 1'b0);
    do_sweep("restart", 8'h02, 1'b0, 1'b0);
    do_sweep("ext_good", 8'h00, 1'b0, 1'b0);

    // Start pulse during vector 3 is ignored.
    do_sweep("poke", 8'h02, 1'b0, 1'b1);

    // Reset in the middle of vector 5.
    ui_in = 8'h02;
    tick(4);
    ui_in = 8'h03;
    tick(3 + 15);
    check("midrst pre uio", uio_out, 8'h05);
    check("midrst pre uo", uo_out, 8'h01);
    rst_n = 1'b0;
    ui_in = 8'h02;
    tick(1);
    check("midrst uo", uo_out, 8'h00);
    check("midrst uio", uio_out, 8'h00);
    rst_n = 1'b1;
    tick(1);
    do_sweep("after_rst", 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
